// File: rtl/flash_cmd_pkg.sv
// flash_cmd_pkg
// Shared constants and state encodings for the UART-to-flash command engine.
// Holds the command opcodes, reply bytes, the 4-bit parser/TX state encoding
// and the flash bus sequencer state encoding.
package flash_cmd_pkg;

    // Command opcodes received from the UART
    localparam logic [7:0] OP_READ   = 8'h52;
    localparam logic [7:0] OP_WRITE  = 8'h57;
    localparam logic [7:0] OP_STATUS = 8'h53;

    // Reply bytes
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // Parser / transmit state encoding
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_WDATA    = 4'd2;
    localparam logic [3:0] ST_RD       = 4'd3;
    localparam logic [3:0] ST_WR       = 4'd4;
    localparam logic [3:0] ST_WAIT_RDY = 4'd5;
    localparam logic [3:0] ST_TX_LOAD  = 4'd6;
    localparam logic [3:0] ST_TX_WAIT1 = 4'd7;
    localparam logic [3:0] ST_TX_DRAIN = 4'd8;

    typedef enum logic [3:0] {
        IDLE     = ST_IDLE,
        ADDR     = ST_ADDR,
        WDATA    = ST_WDATA,
        RD       = ST_RD,
        WR       = ST_WR,
        WAIT_RDY = ST_WAIT_RDY,
        TX_LOAD  = ST_TX_LOAD,
        TX_WAIT1 = ST_TX_WAIT1,
        TX_DRAIN = ST_TX_DRAIN
    } state_t;

    // Flash bus sequencer states
    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_READ   = 3'd1,
        SEQ_WSETUP = 3'd2,
        SEQ_WLOW   = 3'd3,
        SEQ_WHOLD  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/flash_bus_seq.sv
// flash_bus_seq
// Generates the NOR flash strobe timing for one read or one write cycle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, we       : begin a cycle this clock; we=1 selects write
//   addr, wdata     : word address and write data, sampled with start
//   flash_dq_i      : read data from the flash
//   flash_a, flash_dq_o, flash_dq_oe, flash_nce, flash_noe, flash_nwe : flash pins
//   done            : one-cycle pulse once the cycle has fully released the bus
//   rdata           : read data captured on the last access cycle
module flash_bus_seq
    import flash_cmd_pkg::*;
#(
    parameter int ACCESS_CYCLES = 6,
    parameter int WE_CYCLES     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        we,
    input  logic [25:0] addr,
    input  logic [15:0] wdata,
    input  logic [15:0] flash_dq_i,
    output logic [25:0] flash_a,
    output logic [15:0] flash_dq_o,
    output logic        flash_dq_oe,
    output logic        flash_nce,
    output logic        flash_noe,
    output logic        flash_nwe,
    output logic        done,
    output logic [15:0] rdata
);

    localparam logic [3:0] ACC_LAST = 4'(ACCESS_CYCLES - 1);
    localparam logic [3:0] WE_LAST  = 4'(WE_CYCLES - 1);

    seq_state_t seq_state;
    logic [3:0] cnt;

    // All strobes are registered so the pins never glitch. The read path
    // only lowers noe and the write path only lowers nwe, and dq_oe is only
    // raised on the write path, which keeps noe/nwe/dq_oe mutually exclusive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_state   <= SEQ_IDLE;
            cnt         <= 4'd0;
            flash_a     <= 26'd0;
            flash_dq_o  <= 16'd0;
            flash_dq_oe <= 1'b0;
            flash_nce   <= 1'b1;
            flash_noe   <= 1'b1;
            flash_nwe   <= 1'b1;
            done        <= 1'b0;
            rdata       <= 16'd0;
        end else begin
            done <= 1'b0;
            case (seq_state)
                SEQ_IDLE: begin
                    if (start) begin
                        flash_a   <= addr;
                        flash_nce <= 1'b0;
                        cnt       <= 4'd0;
                        if (we) begin
                            flash_dq_o  <= wdata;
                            flash_dq_oe <= 1'b1;
                            seq_state   <= SEQ_WSETUP;
                        end else begin
                            flash_noe <= 1'b0;
                            seq_state <= SEQ_READ;
                        end
                    end
                end
                SEQ_READ: begin
                    // Data is sampled at the end of the last access cycle
                    if (cnt == ACC_LAST) begin
                        rdata     <= flash_dq_i;
                        flash_noe <= 1'b1;
                        flash_nce <= 1'b1;
                        done      <= 1'b1;
                        seq_state <= SEQ_IDLE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SEQ_WSETUP: begin
                    flash_nwe <= 1'b0;
                    cnt       <= 4'd0;
                    seq_state <= SEQ_WLOW;
                end
                SEQ_WLOW: begin
                    if (cnt == WE_LAST) begin
                        flash_nwe <= 1'b1;
                        seq_state <= SEQ_WHOLD;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                SEQ_WHOLD: begin
                    flash_nce   <= 1'b1;
                    flash_dq_oe <= 1'b0;
                    done        <= 1'b1;
                    seq_state   <= SEQ_IDLE;
                end
                default: seq_state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/flash_cmd_ctrl.sv
// flash_cmd_ctrl
// UART byte command parser driving a parallel NOR flash. Accepts 'R' (read),
// 'W' (write + wait for ready) and 'S' (status) commands and returns reply
// bytes through the UART transmitter handshake.
// Ports:
//   clk, rst_n              : 48 MHz clock, asynchronous active-low reset
//   rx_data, rx_rdy         : received byte and its one-cycle strobe
//   tx_data, tx_rdy, tx_busy: byte to send, one-cycle send strobe, UART active
//   flash_*                 : flash address, data, strobes and RY/BY
//   busy                    : high whenever a command is in progress
module flash_cmd_ctrl
    import flash_cmd_pkg::*;
#(
    parameter int          ACCESS_CYCLES = 6,
    parameter int          WE_CYCLES     = 4,
    parameter logic [23:0] READY_TIMEOUT = 24'd4_800_000,
    parameter logic [19:0] IDLE_TIMEOUT  = 20'd480_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic [7:0]  tx_data,
    output logic        tx_rdy,
    input  logic        tx_busy,
    output logic [25:0] flash_a,
    output logic [15:0] flash_dq_o,
    input  logic [15:0] flash_dq_i,
    output logic        flash_dq_oe,
    output logic        flash_nce,
    output logic        flash_noe,
    output logic        flash_nwe,
    input  logic        flash_ready,
    output logic        busy
);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        op_write;
    logic [25:0] addr_sr;
    logic [15:0] wdata_sr;
    logic [15:0] tx_buf;
    logic [1:0]  tx_left;
    logic [23:0] wait_cnt;
    logic [19:0] idle_cnt;

    logic        seq_start;
    logic        seq_we;
    logic [25:0] seq_addr;
    logic [15:0] seq_wdata;
    logic        seq_done;
    logic [15:0] seq_rdata;

    // The flash cycle is launched in the same clock that accepts the final
    // command byte, so the byte is folded straight into the address/data
    // handed to the sequencer instead of waiting for the shift registers.
    assign seq_start = rx_rdy &&
                       (((state == ADDR) && (byte_cnt == 2'd3) && !op_write) ||
                        ((state == WDATA) && (byte_cnt == 2'd1)));
    assign seq_we    = (state == WDATA);
    assign seq_addr  = (state == ADDR) ? {addr_sr[17:0], rx_data} : addr_sr;
    assign seq_wdata = {wdata_sr[7:0], rx_data};
    assign busy      = (state != IDLE);

    flash_bus_seq #(
        .ACCESS_CYCLES (ACCESS_CYCLES),
        .WE_CYCLES     (WE_CYCLES)
    ) u_bus_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (seq_start),
        .we          (seq_we),
        .addr        (seq_addr),
        .wdata       (seq_wdata),
        .flash_dq_i  (flash_dq_i),
        .flash_a     (flash_a),
        .flash_dq_o  (flash_dq_o),
        .flash_dq_oe (flash_dq_oe),
        .flash_nce   (flash_nce),
        .flash_noe   (flash_noe),
        .flash_nwe   (flash_nwe),
        .done        (seq_done),
        .rdata       (seq_rdata)
    );

    // Command parser and reply transmitter. Replies are queued in tx_buf
    // high byte first; tx_left says how many bytes remain to be sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= 2'd0;
            op_write <= 1'b0;
            addr_sr  <= 26'd0;
            wdata_sr <= 16'd0;
            tx_buf   <= 16'd0;
            tx_left  <= 2'd0;
            wait_cnt <= 24'd0;
            idle_cnt <= 20'd0;
            tx_data  <= 8'd0;
            tx_rdy   <= 1'b0;
        end else begin
            tx_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        byte_cnt <= 2'd0;
                        idle_cnt <= 20'd0;
                        case (rx_data)
                            OP_READ: begin
                                op_write <= 1'b0;
                                state    <= ADDR;
                            end
                            OP_WRITE: begin
                                op_write <= 1'b1;
                                state    <= ADDR;
                            end
                            OP_STATUS: begin
                                tx_buf  <= {7'd0, flash_ready, 8'h00};
                                tx_left <= 2'd1;
                                state   <= TX_LOAD;
                            end
                            default: begin
                                tx_buf  <= {RSP_NAK, 8'h00};
                                tx_left <= 2'd1;
                                state   <= TX_LOAD;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    // A byte arriving in the expiry cycle wins over the timeout
                    if (rx_rdy) begin
                        idle_cnt <= 20'd0;
                        addr_sr  <= {addr_sr[17:0], rx_data};
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= 2'd0;
                            state    <= op_write ? WDATA : RD;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (idle_cnt == IDLE_TIMEOUT - 20'd1) begin
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                end
                WDATA: begin
                    if (rx_rdy) begin
                        idle_cnt <= 20'd0;
                        wdata_sr <= {wdata_sr[7:0], rx_data};
                        if (byte_cnt == 2'd1) begin
                            byte_cnt <= 2'd0;
                            state    <= WR;
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (idle_cnt == IDLE_TIMEOUT - 20'd1) begin
                        state <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 20'd1;
                    end
                end
                RD: begin
                    if (seq_done) begin
                        tx_buf  <= seq_rdata;
                        tx_left <= 2'd2;
                        state   <= TX_LOAD;
                    end
                end
                WR: begin
                    if (seq_done) begin
                        wait_cnt <= 24'd0;
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    // RY/BY takes a couple of cycles to fall after the write,
                    // so it is not trusted during the first two cycles.
                    if ((wait_cnt >= 24'd2) && flash_ready) begin
                        tx_buf  <= {RSP_ACK, 8'h00};
                        tx_left <= 2'd1;
                        state   <= TX_LOAD;
                    end else if (wait_cnt == READY_TIMEOUT - 24'd1) begin
                        tx_buf  <= {RSP_NAK, 8'h00};
                        tx_left <= 2'd1;
                        state   <= TX_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 24'd1;
                    end
                end
                TX_LOAD: begin
                    if (!tx_busy) begin
                        tx_data <= tx_buf[15:8];
                        tx_buf  <= {tx_buf[7:0], 8'h00};
                        tx_left <= tx_left - 2'd1;
                        tx_rdy  <= 1'b1;
                        state   <= TX_WAIT1;
                    end
                end
                TX_WAIT1: begin
                    // The UART raises txactive one cycle late; skip that cycle
                    state <= TX_DRAIN;
                end
                TX_DRAIN: begin
                    if (!tx_busy) begin
                        state <= (tx_left != 2'd0) ? TX_LOAD : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_cmd_ctrl.sv
// tb_flash_cmd_ctrl
// Directed testbench for flash_cmd_ctrl with a reply scoreboard, a simple
// UART transmitter model and a NOR flash model (fixed read data, RY/BY low
// for 100 cycles after each write, or stuck low on demand).
module tb_flash_cmd_ctrl;

    localparam int IDLE_T = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_rdy;
    logic        tx_busy = 1'b0;
    logic [25:0] flash_a;
    logic [15:0] flash_dq_o;
    logic [15:0] flash_dq_i;
    logic        flash_dq_oe;
    logic        flash_nce;
    logic        flash_noe;
    logic        flash_nwe;
    logic        flash_ready = 1'b1;
    logic        busy;

    logic [15:0] flash_mem = 16'hBEEF;
    logic        ready_stuck = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] exp_q[$];

    int          cycle = 0;
    int          noe_run = 0;
    int          last_noe_len = 0;
    logic [25:0] rd_addr = 26'd0;
    int          nwe_run = 0;
    int          last_nwe_len = 0;
    int          nwe_rise_cycle = 0;
    logic [25:0] wr_addr = 26'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_oe = 1'b0;
    int          ready_low = 0;
    int          excl_bad = 0;
    int          nce_cycles = 0;
    int          tx_count = 0;
    int          tx_cycle = 0;
    logic        ready_at_tx = 1'b0;
    int          tx_run = 0;
    int          max_tx_run = 0;
    int          busy_left = 0;

    assign flash_dq_i = (!flash_nce && !flash_noe) ? flash_mem : 16'h0000;

    always #5 clk = ~clk;

    flash_cmd_ctrl #(
        .ACCESS_CYCLES (6),
        .WE_CYCLES     (4),
        .READY_TIMEOUT (24'd1000),
        .IDLE_TIMEOUT  (20'(IDLE_T))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .tx_data     (tx_data),
        .tx_rdy      (tx_rdy),
        .tx_busy     (tx_busy),
        .flash_a     (flash_a),
        .flash_dq_o  (flash_dq_o),
        .flash_dq_i  (flash_dq_i),
        .flash_dq_oe (flash_dq_oe),
        .flash_nce   (flash_nce),
        .flash_noe   (flash_noe),
        .flash_nwe   (flash_nwe),
        .flash_ready (flash_ready),
        .busy        (busy)
    );

    // Single comparison point: counts every check and reports failures
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Send one UART byte as a one-cycle strobe followed by a short gap
    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic waitTxCount(input int target, input int budget, input string tag);
        int i = 0;
        while (tx_count < target && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, 32'(tx_count), 32'(target));
    endtask

    task automatic waitIdle(input int budget, input string tag);
        int i = 0;
        while (busy && i < budget) begin
            @(negedge clk);
            i++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    // Bus monitor, flash RY/BY model, UART tx model and reply scoreboard
    initial begin
        forever begin
            @(negedge clk);
            cycle++;

            if (!flash_noe) begin
                if (noe_run == 0) rd_addr = flash_a;
                noe_run++;
            end else if (noe_run != 0) begin
                last_noe_len = noe_run;
                noe_run = 0;
            end

            if (!flash_nwe) begin
                if (nwe_run == 0) begin
                    wr_addr = flash_a;
                    wr_data = flash_dq_o;
                    wr_oe   = flash_dq_oe;
                end
                nwe_run++;
            end else if (nwe_run != 0) begin
                last_nwe_len = nwe_run;
                nwe_run = 0;
                nwe_rise_cycle = cycle;
                ready_low = 100;
            end else if (ready_low > 0) begin
                ready_low--;
            end
            flash_ready = !ready_stuck && (ready_low == 0);

            if ((!flash_noe && !flash_nwe) || (flash_dq_oe && !flash_noe)) excl_bad++;
            if (!flash_nce) nce_cycles++;

            if (tx_rdy) begin
                tx_run++;
                tx_count++;
                tx_cycle = cycle;
                ready_at_tx = flash_ready;
                busy_left = 30;
                if (exp_q.size() == 0)
                    checkOutput("tx_unexpected_pending", 32'(exp_q.size()), 32'd1);
                else
                    checkOutput("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end else begin
                tx_run = 0;
            end
            if (tx_run > max_tx_run) max_tx_run = tx_run;

            tx_busy = (busy_left != 0);
            if (busy_left != 0) busy_left--;
        end
    end

    // Directed test sequence
    initial begin
        int base;
        int nce_base;
        int i;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_strobes", 32'({flash_nce, flash_noe, flash_nwe, flash_dq_oe}), 32'b1110);
        checkOutput("rst_addr", 32'(flash_a), 32'd0);
        checkOutput("rst_dq_o", 32'(flash_dq_o), 32'd0);
        checkOutput("rst_tx", 32'({tx_rdy, tx_data, busy}), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Read 0x0012345, flash returns BEEF
        $display("[TB] read command");
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        applyStimulus(8'h23);
        applyStimulus(8'h45);
        waitTxCount(2, 500, "rd_reply_count");
        waitIdle(200, "rd_idle");
        checkOutput("rd_addr", 32'(rd_addr), 32'h0012345);
        checkOutput("rd_noe_len", 32'(last_noe_len), 32'd6);

        // Write A55A to 0x10, ready low for 100 cycles
        $display("[TB] write command");
        exp_q.push_back(8'h06);
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        waitTxCount(3, 500, "wr_reply_count");
        waitIdle(200, "wr_idle");
        checkOutput("wr_nwe_len", 32'(last_nwe_len), 32'd4);
        checkOutput("wr_data", 32'(wr_data), 32'hA55A);
        checkOutput("wr_addr", 32'(wr_addr), 32'h10);
        checkOutput("wr_dq_oe", 32'(wr_oe), 32'd1);
        checkOutput("wr_ready_at_reply", 32'(ready_at_tx), 32'd1);
        checkOutput("wr_reply_after_ready", 32'((tx_cycle - nwe_rise_cycle) >= 100), 32'd1);

        // Same write with RY/BY stuck low: NAK after the ready timeout
        $display("[TB] write timeout");
        ready_stuck = 1'b1;
        exp_q.push_back(8'h15);
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h10);
        applyStimulus(8'hA5);
        applyStimulus(8'h5A);
        waitTxCount(4, 2000, "wr_to_reply_count");
        waitIdle(200, "wr_to_idle");
        checkOutput("wr_to_window",
                    32'(((tx_cycle - nwe_rise_cycle) >= 1000) && ((tx_cycle - nwe_rise_cycle) <= 1010)),
                    32'd1);
        ready_stuck = 1'b0;
        repeat (150) @(negedge clk);

        // Status and unknown opcode leave the flash pins alone
        $display("[TB] status and unknown opcode");
        nce_base = nce_cycles;
        exp_q.push_back(8'h01);
        applyStimulus(8'h53);
        waitTxCount(5, 200, "st_reply_count");
        waitIdle(200, "st_idle");
        exp_q.push_back(8'h15);
        applyStimulus(8'h77);
        waitTxCount(6, 200, "unk_reply_count");
        waitIdle(200, "unk_idle");
        checkOutput("st_unk_no_flash", 32'(nce_cycles), 32'(nce_base));

        // Partial command abandoned by the inter-byte timeout
        $display("[TB] partial command");
        nce_base = nce_cycles;
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'h01);
        checkOutput("part_busy", 32'(busy), 32'd1);
        repeat (IDLE_T + 20) @(negedge clk);
        checkOutput("part_timeout_idle", 32'(busy), 32'd0);
        checkOutput("part_no_reply", 32'(tx_count), 32'd6);
        checkOutput("part_no_flash", 32'(nce_cycles), 32'(nce_base));
        exp_q.push_back(8'h01);
        applyStimulus(8'h53);
        waitTxCount(7, 200, "part_status_count");
        waitIdle(200, "part_status_idle");

        // Bytes arriving during the read reply are dropped
        $display("[TB] bytes during reply");
        base = tx_count;
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        applyStimulus(8'h52);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h07);
        waitTxCount(base + 1, 500, "drop_first_byte");
        applyStimulus(8'h53);
        applyStimulus(8'h77);
        waitTxCount(base + 2, 500, "drop_second_byte");
        waitIdle(200, "drop_idle");
        repeat (100) @(negedge clk);
        checkOutput("drop_exact_two", 32'(tx_count - base), 32'd2);

        // Reset asserted while nwe is low
        $display("[TB] reset during write");
        base = tx_count;
        applyStimulus(8'h57);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h00);
        applyStimulus(8'h20);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        i = 0;
        while (flash_nwe && i < 100) begin
            @(negedge clk);
            i++;
        end
        checkOutput("rstw_nwe_low", 32'(flash_nwe), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_strobes", 32'({flash_nce, flash_noe, flash_nwe, flash_dq_oe}), 32'b1110);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        checkOutput("rstw_no_reply", 32'(tx_count), 32'(base));
        checkOutput("rstw_busy", 32'(busy), 32'd0);

        // Whole-run properties
        checkOutput("bus_exclusion", 32'(excl_bad), 32'd0);
        checkOutput("tx_rdy_pulse_max", 32'(max_tx_run), 32'd1);
        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
